rms_channel_scheduler: RTL and testbench
========================================

Name: rms_channel_scheduler

Overview:
- Shares one power-RMS computation unit between NCH BPM electrode channels.
- Each channel has an event sample buffer. The scheduler grants channels round-robin and streams the granted buffer as one contiguous valid burst into the RMS unit.
- It waits for the unit's ready pulse, captures the RMS and sample count, and reports per-channel completion.
- Sits between the per-electrode capture buffers and the RMS unit in the BPM acquisition path.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- LEN_W, 12, width of per-channel burst length.
- MIN_LEN, 3, minimum burst length the RMS unit accepts.
- RESULT_DELAY, 8, cycles from rms_rdy to a stable rms_result (sqrt latency).
- TIMEOUT, 1024, maximum cycles to wait for rms_rdy after the burst ends.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ch_req  in  NCH  level request per channel; data ready in buffer
- ch_len  in  NCH*LEN_W  burst length per channel; slice i belongs to channel i
- ch_ack  out  NCH  one-cycle completion pulse per channel
- buf_sel  out  $clog2(NCH)  buffer select (granted channel)
- buf_addr  out  LEN_W  buffer read address
- buf_rd_en  out  1  buffer read strobe; data returns the next cycle
- buf_data  in  16  buffer read data (signed)
- rms_data  out  16  sample to the RMS unit
- rms_valid  out  1  sample valid to the RMS unit
- rms_rdy  in  1  RMS unit completion pulse
- rms_result  in  32  RMS unit float result
- rms_n  in  16  RMS unit sample count
- result_rms  out  32  captured RMS
- result_n  out  16  captured count
- result_ch  out  $clog2(NCH)  channel of the captured result
- result_valid  out  1  one-cycle strobe; result_* stable until the next strobe
- busy  out  1  high from grant to ack
- err  out  1  one-cycle pulse with ch_ack on a rejected or timed-out job

Behaviour:
- Reset (rst low, async): every output is 0, state IDLE, round-robin pointer 0, counters 0. Reset mid-burst drops rms_valid immediately; no ack is issued for the aborted job.
- IDLE: if any ch_req bit is set, go to ARB. Otherwise remain in IDLE.
- ARB (1 cycle):
  - Grant the first requesting channel at or after the pointer, wrapping modulo NCH.
  - Latch the granted channel and its length L. Set busy=1.
  - Advance the pointer to grant+1 (wraps).
  - If L < MIN_LEN: go to ACK with err=1.
  - Otherwise go to PRIME.
- PRIME: buf_rd_en=1, buf_addr=0.
- STREAM:
  - Register rms_data<=buf_data and rms_valid<=1 each cycle.
  - Keep reading addresses 1..L-1 back-to-back.
  - rms_valid is high for exactly L consecutive cycles with no bubbles.
  - buf_rd_en deasserts after address L-1 is issued.
- GAP: rms_valid=0. This falling edge terminates the unit's accumulation. Start the timeout counter and go to WAIT_RDY.
- WAIT_RDY:
  - On rms_rdy, go to SETTLE.
  - If the counter reaches TIMEOUT, go to ACK with err=1; result_valid is not asserted.
- SETTLE: wait RESULT_DELAY cycles, then capture rms_result, rms_n, and the channel into result_*. Pulse result_valid.
- ACK: pulse ch_ack[grant] (and err if set), clear busy, return to IDLE.
  - Minimum of 1 idle cycle between jobs, so the unit sees valid low for at least 2 cycles.
- ch_req deasserted during a job: ignored; the job completes.
- ch_req still high after ack: the channel is re-eligible. Round robin prevents starvation.
- rms_rdy outside WAIT_RDY: ignored.
- buf_addr range is 0..L-1. L=2^LEN_W-1 is legal; the address never wraps.
- rms_n is not checked against L (the unit reports its own count); it is passed through unmodified.

Test Plan:
- Single request: ch_req=0001, len=5, buffer 1,2,3,4,5; unit returns rdy → rms_valid high exactly 5 cycles carrying 1..5 in order; after RESULT_DELAY, result_ch=0, result_valid pulse, then ch_ack=0001.
- All four channels requesting simultaneously, pointer=0 → grant order 0,1,2,3. With ch0 re-requesting immediately, the next order is 0 after 3, not 0,0.
- len=2 on ch2 → no read and no rms_valid; ch_ack[2] and err pulse together 2 cycles after grant.
- rms_rdy never asserted → err and ch_ack pulse TIMEOUT cycles after rms_valid falls; result_valid stays 0; the next channel is then serviced.
- rst low in the third STREAM cycle → rms_valid, busy, and buf_rd_en are 0 without waiting for clk. After release, a pending request restarts from address 0.
- ch_req dropped mid-burst → the full L-sample burst still completes and is acked.

Source files
------------

// File: rtl/rms_channel_scheduler_if.sv
// Channel-request, sample-buffer and RMS-unit signals of the RMS channel scheduler.
// master = scheduler side, slave = capture buffers / RMS unit / result consumer.
interface rms_channel_scheduler_if #(
  parameter int NCH   = 4,
  parameter int LEN_W = 12
);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]       ch_req;
  logic [NCH*LEN_W-1:0] ch_len;
  logic [NCH-1:0]       ch_ack;
  logic [SEL_W-1:0]     buf_sel;
  logic [LEN_W-1:0]     buf_addr;
  logic                 buf_rd_en;
  logic [15:0]          buf_data;
  logic [15:0]          rms_data;
  logic                 rms_valid;
  logic                 rms_rdy;
  logic [31:0]          rms_result;
  logic [15:0]          rms_n;
  logic [31:0]          result_rms;
  logic [15:0]          result_n;
  logic [SEL_W-1:0]     result_ch;
  logic                 result_valid;
  logic                 busy;
  logic                 err;

  modport master (
    input  ch_req, ch_len, buf_data, rms_rdy, rms_result, rms_n,
    output ch_ack, buf_sel, buf_addr, buf_rd_en, rms_data, rms_valid,
           result_rms, result_n, result_ch, result_valid, busy, err
  );

  modport slave (
    output ch_req, ch_len, buf_data, rms_rdy, rms_result, rms_n,
    input  ch_ack, buf_sel, buf_addr, buf_rd_en, rms_data, rms_valid,
           result_rms, result_n, result_ch, result_valid, busy, err
  );
endinterface

// File: rtl/rms_channel_scheduler.sv
// Round-robin scheduler sharing one RMS unit between NCH electrode sample buffers.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no job; any request moves to ARB
// ARB      | pick channel round-robin, latch length, reject short bursts
// PRIME    | read address 0 issued to the buffer
// STREAM   | one sample per cycle into the RMS unit, L cycles back-to-back
// GAP      | drop rms_valid to close the accumulation, arm the timeout
// WAIT_RDY | wait for rms_rdy or timeout
// SETTLE   | let the sqrt result settle, then capture result_*
// ACK      | pulse ch_ack (and err), release busy
module rms_channel_scheduler #(
  parameter int NCH          = 4,
  parameter int LEN_W        = 12,
  parameter int MIN_LEN      = 3,
  parameter int RESULT_DELAY = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  rms_channel_scheduler_if.master bus
);

  localparam int SEL_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TMR_MAX = (TIMEOUT > RESULT_DELAY) ? TIMEOUT : RESULT_DELAY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Loads are terminal-count minus the fixed state overhead around each wait.
  localparam logic [TMR_W-1:0] TMO_LOAD    = TMR_W'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'((RESULT_DELAY > 0) ? RESULT_DELAY - 1 : 0);
  localparam logic [LEN_W-1:0] MIN_LEN_L   = LEN_W'(MIN_LEN);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    PRIME,
    STREAM,
    GAP,
    WAIT_RDY,
    SETTLE,
    ACK
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] sample_cnt;
  logic [LEN_W-1:0] last_addr;
  logic [TMR_W-1:0] tmr;
  logic             err_q;

  logic [LEN_W-1:0] len_arr [NCH];
  logic             gnt_found;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] cand;

  for (genvar g = 0; g < NCH; g++) begin : g_len
    assign len_arr[g] = bus.ch_len[g*LEN_W +: LEN_W];
  end

  assign last_addr = len_q - 1'b1;

  // First requester at or after the pointer, wrapping modulo NCH.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = SEL_W'((int'(rr_ptr) + i) % NCH);
      if (!gnt_found && bus.ch_req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      grant_q          <= '0;
      len_q            <= '0;
      sample_cnt       <= '0;
      tmr              <= '0;
      err_q            <= 1'b0;
      bus.ch_ack       <= '0;
      bus.buf_sel      <= '0;
      bus.buf_addr     <= '0;
      bus.buf_rd_en    <= 1'b0;
      bus.rms_data     <= '0;
      bus.rms_valid    <= 1'b0;
      bus.result_rms   <= '0;
      bus.result_n     <= '0;
      bus.result_ch    <= '0;
      bus.result_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      bus.ch_ack       <= '0;
      bus.err          <= 1'b0;
      bus.result_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (|bus.ch_req) state <= ARB;
        end

        ARB: begin
          if (gnt_found) begin
            grant_q     <= gnt_idx;
            bus.buf_sel <= gnt_idx;
            len_q       <= len_arr[gnt_idx];
            sample_cnt  <= '0;
            bus.busy    <= 1'b1;
            rr_ptr      <= (gnt_idx == SEL_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            if (len_arr[gnt_idx] < MIN_LEN_L) begin
              err_q <= 1'b1;
              state <= ACK;
            end else begin
              bus.buf_addr  <= '0;
              bus.buf_rd_en <= 1'b1;
              state         <= PRIME;
            end
          end else begin
            state <= IDLE;
          end
        end

        PRIME: begin
          if (len_q == LEN_W'(1)) bus.buf_rd_en <= 1'b0;
          else                    bus.buf_addr  <= LEN_W'(1);
          state <= STREAM;
        end

        // Address stalls at L-1 so a full-scale length never wraps to 0.
        STREAM: begin
          bus.rms_data  <= bus.buf_data;
          bus.rms_valid <= 1'b1;
          if (bus.buf_addr == last_addr) bus.buf_rd_en <= 1'b0;
          else                           bus.buf_addr  <= bus.buf_addr + 1'b1;
          if (sample_cnt == last_addr) state      <= GAP;
          else                         sample_cnt <= sample_cnt + 1'b1;
        end

        GAP: begin
          bus.rms_valid <= 1'b0;
          bus.rms_data  <= '0;
          bus.buf_addr  <= '0;
          tmr           <= TMO_LOAD;
          state         <= WAIT_RDY;
        end

        WAIT_RDY: begin
          if (bus.rms_rdy) begin
            tmr   <= SETTLE_LOAD;
            state <= SETTLE;
          end else if (tmr == '0) begin
            err_q <= 1'b1;
            state <= ACK;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        SETTLE: begin
          if (tmr == '0) begin
            bus.result_rms   <= bus.rms_result;
            bus.result_n     <= bus.rms_n;
            bus.result_ch    <= grant_q;
            bus.result_valid <= 1'b1;
            state            <= ACK;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        ACK: begin
          bus.ch_ack <= NCH'(1) << grant_q;
          bus.err    <= err_q;
          err_q      <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rms_channel_scheduler.sv
// Directed bench for rms_channel_scheduler: buffer stub, hand-driven RMS unit,
// immediate assertions at each observation point (sampled on the falling edge).
module tb_rms_channel_scheduler;

  localparam int NCH          = 4;
  localparam int LEN_W        = 12;
  localparam int MIN_LEN      = 3;
  localparam int RESULT_DELAY = 8;
  localparam int TIMEOUT      = 1024;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rms_channel_scheduler_if #(.NCH(NCH), .LEN_W(LEN_W)) bus ();

  rms_channel_scheduler #(
    .NCH(NCH), .LEN_W(LEN_W), .MIN_LEN(MIN_LEN),
    .RESULT_DELAY(RESULT_DELAY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [15:0] buf_val(input int ch, input int a);
    return 16'(ch * 4096 + a + 1);
  endfunction

  // Sample buffer: one-cycle read latency.
  always @(posedge clk)
    if (bus.buf_rd_en) bus.buf_data <= buf_val(int'(bus.buf_sel), int'(bus.buf_addr));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int ch, input int len);
    bus.ch_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  // Request raised while idle: busy is seen two falling edges later.
  task automatic wait_busy(input string tag);
    int n = 0;
    while (!bus.busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'd2);
  endtask

  // Entered on the PRIME cycle; returns on the first cycle with rms_valid low.
  task automatic stream_check(input int ch, input int len);
    int rd = 0;
    check("prime_sel", 64'(bus.buf_sel), 64'(ch));
    check("prime_addr", 64'(bus.buf_addr), 64'd0);
    check("prime_rd", 64'(bus.buf_rd_en), 64'd1);
    for (int c = 0; c < len + 2; c++) begin
      if (bus.buf_rd_en) rd++;
      if (c >= 2)
        check("stream_sample", {47'd0, bus.rms_valid, bus.rms_data},
              {47'd0, 1'b1, buf_val(ch, c - 2)});
      else
        check("stream_pre", 64'(bus.rms_valid), 64'd0);
      tick();
      bus.rms_rdy = 1'b0;
    end
    check("gap_valid", 64'(bus.rms_valid), 64'd0);
    check("rd_count", 64'(rd), 64'(len));
    check("gap_busy", 64'(bus.busy), 64'd1);
  endtask

  // Entered on the first WAIT_RDY cycle; returns on the ack cycle.
  task automatic finish_rdy(input int ch, input int delay, input logic [15:0] n);
    logic [31:0] res = 32'h4000_0000 + 32'(ch);
    for (int d = 0; d < delay; d++) tick();
    bus.rms_rdy    = 1'b1;
    bus.rms_result = 32'hDEAD_BEEF;
    bus.rms_n      = 16'hBAD0;
    tick();
    bus.rms_rdy = 1'b0;
    for (int k = 1; k < RESULT_DELAY; k++) begin
      check("settle_quiet", 64'(bus.result_valid), 64'd0);
      tick();
    end
    bus.rms_result = res;
    bus.rms_n      = n;
    check("settle_last", 64'(bus.result_valid), 64'd0);
    tick();
    check("res_valid", 64'(bus.result_valid), 64'd1);
    check("res_rms", 64'(bus.result_rms), 64'(res));
    check("res_n", 64'(bus.result_n), 64'(n));
    check("res_ch", 64'(bus.result_ch), 64'(ch));
    check("res_noack", 64'(bus.ch_ack), 64'd0);
    tick();
    check("ack", 64'(bus.ch_ack), 64'(1) << ch);
    check("ack_err", 64'(bus.err), 64'd0);
    check("ack_busy", 64'(bus.busy), 64'd0);
    check("res_strobe", 64'(bus.result_valid), 64'd0);
    check("res_hold", 64'(bus.result_rms), 64'(res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;

    rst            = 1'b0;
    bus.ch_req     = '0;
    bus.ch_len     = '0;
    bus.rms_rdy    = 1'b0;
    bus.rms_result = '0;
    bus.rms_n      = '0;
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.rms_valid), 64'd0);
    check("rst_rd", 64'(bus.buf_rd_en), 64'd0);
    check("rst_ack", 64'(bus.ch_ack), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_rv", 64'(bus.result_valid), 64'd0);
    check("rst_addr", 64'(bus.buf_addr), 64'd0);
    check("rst_sel", 64'(bus.buf_sel), 64'd0);
    check("rst_rms", 64'(bus.result_rms), 64'd0);
    check("rst_n", 64'(bus.result_n), 64'd0);
    check("rst_rch", 64'(bus.result_ch), 64'd0);
    check("rst_data", 64'(bus.rms_data), 64'd0);
    rst = 1'b1;

    // Single request on ch0, five samples 1..5.
    set_len(0, 5);
    bus.ch_req = 4'b0001;
    wait_busy("b_grant");
    bus.ch_req = 4'b0000;
    stream_check(0, 5);
    finish_rdy(0, 0, 16'd5);

    // Short burst on ch2: rejected without any read.
    set_len(2, 2);
    bus.ch_req = 4'b0100;
    wait_busy("c_grant");
    check("c_sel", 64'(bus.buf_sel), 64'd2);
    check("c_no_rd", 64'(bus.buf_rd_en), 64'd0);
    check("c_ack_early", 64'(bus.ch_ack), 64'd0);
    bus.ch_req = 4'b0000;
    tick();
    check("c_ack", 64'(bus.ch_ack), 64'(4'b0100));
    check("c_err", 64'(bus.err), 64'd1);
    check("c_busy", 64'(bus.busy), 64'd0);
    check("c_valid", 64'(bus.rms_valid), 64'd0);
    check("c_rd", 64'(bus.buf_rd_en), 64'd0);
    tick();
    check("c_err_pulse", 64'(bus.err), 64'd0);

    // Timeout on ch3 (pointer at 3), then ch1 is serviced.
    set_len(3, 3);
    set_len(1, 4);
    bus.ch_req = 4'b1010;
    wait_busy("d_grant");
    bus.ch_req = 4'b0010;
    stream_check(3, 3);
    n    = 0;
    seen = 1'b0;
    while (bus.ch_ack == '0 && n < TIMEOUT + 100) begin
      if (bus.result_valid) seen = 1'b1;
      tick();
      n++;
    end
    check("d_tmo_cycles", 64'(n), 64'(TIMEOUT));
    check("d_tmo_ack", 64'(bus.ch_ack), 64'(4'b1000));
    check("d_tmo_err", 64'(bus.err), 64'd1);
    check("d_tmo_no_rv", 64'(seen), 64'd0);
    wait_busy("d_next");
    bus.ch_req = 4'b0000;
    stream_check(1, 4);
    finish_rdy(1, 2, 16'd4);

    // Reset in the third STREAM cycle of a ch3 job, then restart from address 0.
    set_len(3, 6);
    bus.ch_req = 4'b1000;
    wait_busy("e_grant");
    tick();
    tick();
    tick();
    check("e_pre_valid", 64'(bus.rms_valid), 64'd1);
    check("e_pre_rd", 64'(bus.buf_rd_en), 64'd1);
    check("e_pre_data", 64'(bus.rms_data), 64'(buf_val(3, 1)));
    rst = 1'b0;
    #1;
    check("e_rst_valid", 64'(bus.rms_valid), 64'd0);
    check("e_rst_busy", 64'(bus.busy), 64'd0);
    check("e_rst_rd", 64'(bus.buf_rd_en), 64'd0);
    check("e_rst_ack", 64'(bus.ch_ack), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    wait_busy("e_restart");
    bus.ch_req = 4'b0000;
    stream_check(3, 6);
    finish_rdy(3, 1, 16'd6);

    // All four requesting with pointer 0; ch0 keeps requesting throughout.
    for (int c = 0; c < NCH; c++) set_len(c, 3);
    bus.ch_req = 4'b1111;
    wait_busy("f_g0");
    stream_check(0, 3);
    finish_rdy(0, 0, 16'd3);
    for (int k = 1; k < NCH; k++) begin
      wait_busy("f_gk");
      check("f_order", 64'(bus.buf_sel), 64'(k));
      bus.ch_req[k] = 1'b0;
      stream_check(k, 3);
      finish_rdy(k, 0, 16'd3);
    end
    wait_busy("f_wrap");
    check("f_order_wrap", 64'(bus.buf_sel), 64'd0);
    bus.ch_req = 4'b0000;
    stream_check(0, 3);
    finish_rdy(0, 0, 16'd3);

    // Request dropped at PRIME with a stray rms_rdy; the burst still completes.
    set_len(2, 4);
    bus.ch_req = 4'b0100;
    wait_busy("g_grant");
    bus.ch_req  = 4'b0000;
    bus.rms_rdy = 1'b1;
    stream_check(2, 4);
    finish_rdy(2, 3, 16'd4);

    tick();
    check("end_idle", 64'(bus.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
